banked_mem_unit: RTL and testbench
==================================

Name: banked_mem_unit

Overview:
- Parametrised successor to the fixed 8x4K-word RAM datapath. Holds NUM_BANKS single-port synchronous banks selected by the upper address bits.
- Adds a sequenced request/done handshake, per-bank write protection, and a hardware stack in the top bank with PUSH/POP.
- Sits between the ALU address/data buses and the control unit, which issues one memory op at a time.

Parameters:
- DATA_WIDTH, 64: word width.
- BANK_ADDR_WIDTH, 12: word address bits per bank; DEPTH = 2**BANK_ADDR_WIDTH.
- NUM_BANKS, 8: bank count; must be a power of 2, >= 2. Derived localparam BSEL_W = clog2(NUM_BANKS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  operation request; sampled at the rising edge while ready=1.
- op  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP.
- addr  in  BSEL_W+BANK_ADDR_WIDTH  {bank, word}; ignored for PUSH/POP.
- wr_data  in  DATA_WIDTH  data for STORE/PUSH.
- wp_mask  in  NUM_BANKS  bit i=1 write-protects bank i; sampled with req.
- ready  out  1  can accept req this cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; op rejected.
- rd_data  out  DATA_WIDTH  LOAD/POP result; held until the next done.
- sp  out  BANK_ADDR_WIDTH+1  stack entry count, 0..DEPTH.
- stk_full  out  1  sp==DEPTH.
- stk_empty  out  1  sp==0.

Behaviour:
- Reset (rst=0, async): state IDLE; ready=1; done=0; err=0; rd_data=0; sp=0; stk_empty=1; stk_full=0. Bank contents are not cleared.
- FSM states IDLE, ACCESS, RESP.
  - IDLE→ACCESS on req.
  - ACCESS→RESP always.
  - RESP→ACCESS on req, else IDLE.
- ready=1 in IDLE and RESP, 0 in ACCESS. req while ready=0 is ignored (not queued).
- On the accepting edge E0, op, addr, wr_data, wp_mask and the checked error are latched.
- The bank access happens at edge E1, which ends ACCESS. done, err and rd_data are valid during RESP (the cycle after E1) for exactly one cycle.
  - Latency: req-to-done is 2 cycles.
  - Throughput: one op per 2 cycles.
- LOAD: rd_data <= bank[addr.bank][addr.word]; err=0.
- STORE: write at E1 unless wp_mask[bank]=1. If protected: err=1, no write, rd_data unchanged.
- PUSH: writes the top bank (NUM_BANKS-1) at word sp, and sp increments at E1.
  - Full: err=1, no write, sp unchanged.
  - wp_mask of the top bank does not apply to PUSH.
- POP: rd_data <= top bank[sp-1], and sp decrements at E1.
  - Empty: err=1, sp unchanged, rd_data unchanged.
- LOAD/STORE may address the top bank directly. This gives stack inspection and does not change sp.
- stk_full and stk_empty are combinational from sp and update the cycle after E1.
- Error is decided from sp at E0. Only one op is in flight, so no race is possible.
- Reset asserted before E1 aborts the op: no write, no sp change, no done.
- Unused op encodings: none.

Decomposition:
- Shared package holds:
  - op encodings (OP_LOAD=2'b00, OP_STORE=2'b01, OP_PUSH=2'b10, OP_POP=2'b11);
  - FSM state encodings;
  - the clog2 function.
- Sub-module mem_bank (DATA_WIDTH, ADDR_WIDTH): single-port synchronous RAM with write enable and a registered read, instantiated NUM_BANKS times via generate.
- Bank select uses a one-hot decode of latched addr[top BSEL_W bits]. The output mux selects by the same latched bank index.

Test Plan:
- Reset, then STORE addr=0x1004 data=0xDEAD_BEEF, then LOAD addr=0x1004. Required: done 2 cycles after each req; rd_data=0xDEAD_BEEF; err=0; LOAD from addr=0x0004 is not 0xDEAD_BEEF (bank isolation).
- wp_mask=8'h02, STORE addr=0x1008 data=5, then LOAD addr=0x1008. Required: STORE gives done with err=1; LOAD returns the prior contents.
- PUSH 0x11, 0x22, 0x33 back-to-back (req held high in RESP). Required: sp=3; then POP×3 returns 0x33, 0x22, 0x11; sp=0; stk_empty=1.
- POP at sp=0. Required: err=1, sp=0, rd_data unchanged. Then fill with DEPTH pushes (stk_full=1) and push again: err=1, sp=DEPTH.
- PUSH 0xAB, then LOAD addr=0x7000. Required: rd_data=0xAB.
- Assert rst during ACCESS of a STORE to addr=0x2000 data=7. Required: done never pulses; all outputs at reset values; subsequent LOAD addr=0x2000 does not return 7 (pre-load it with 1 and expect 1).

Source files
------------

// File: rtl/banked_mem_unit_pkg.sv
// Shared definitions for the banked memory unit: op and FSM encodings plus a
// constant-foldable ceiling log2 used to size the bank select field.
package banked_mem_unit_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/banked_mem_unit_bank.sv
// Single-port synchronous RAM bank: write when en&we, registered read when
// en&~we. The read register holds its value while the bank is not read.
module mem_bank #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wr_data;
      else    rd_data   <= mem[addr];
    end
  end

endmodule

// File: rtl/banked_mem_unit.sv
// Banked memory datapath with request/done sequencing, per-bank write
// protection and a hardware stack occupying the top bank.
module banked_mem_unit
  import banked_mem_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BANK_ADDR_WIDTH = 12,
  parameter int unsigned NUM_BANKS       = 8,
  localparam int unsigned BSEL_W         = clog2(NUM_BANKS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req,
  input  logic [1:0]                        op,
  input  logic [BSEL_W+BANK_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [NUM_BANKS-1:0]              wp_mask,
  output logic                              ready,
  output logic                              done,
  output logic                              err,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [BANK_ADDR_WIDTH:0]          sp,
  output logic                              stk_full,
  output logic                              stk_empty
);

  localparam logic [BANK_ADDR_WIDTH:0] SP_FULL  = {1'b1, {BANK_ADDR_WIDTH{1'b0}}};
  localparam logic [BSEL_W-1:0]        TOP_BANK = BSEL_W'(NUM_BANKS - 1);

  state_e                              state_q, state_d;
  op_e                                 op_q;
  logic [BSEL_W+BANK_ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]               wr_data_q;
  logic                                err_q;
  logic [BANK_ADDR_WIDTH:0]            sp_q;
  logic [BSEL_W-1:0]                   rd_bank_q;
  logic                                rd_valid_q;

  logic                                accept;
  logic                                chk_err;
  logic                                exec;
  logic                                bank_we;
  logic [BSEL_W-1:0]                   bank_idx;
  logic [BANK_ADDR_WIDTH-1:0]          word_addr;
  logic [NUM_BANKS-1:0]                bank_en;
  logic [DATA_WIDTH-1:0]               bank_rd [NUM_BANKS];

  assign accept = req && (state_q != ST_ACCESS);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = req ? ST_ACCESS : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Error is resolved at acceptance; nothing else can move sp while in flight.
  always_comb begin
    chk_err = 1'b0;
    unique case (op_e'(op))
      OP_STORE: chk_err = wp_mask[addr[BSEL_W+BANK_ADDR_WIDTH-1 -: BSEL_W]];
      OP_PUSH:  chk_err = (sp_q == SP_FULL);
      OP_POP:   chk_err = (sp_q == '0);
      default:  chk_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      addr_q    <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_e'(op);
        addr_q    <= addr;
        wr_data_q <= wr_data;
        err_q     <= chk_err;
      end
    end
  end

  assign exec     = (state_q == ST_ACCESS) && !err_q;
  assign bank_we  = (op_q == OP_STORE) || (op_q == OP_PUSH);
  assign bank_idx = op_q[1] ? TOP_BANK : addr_q[BSEL_W+BANK_ADDR_WIDTH-1 -: BSEL_W];

  always_comb begin
    word_addr = addr_q[BANK_ADDR_WIDTH-1:0];
    if (op_q == OP_PUSH)     word_addr = sp_q[BANK_ADDR_WIDTH-1:0];
    else if (op_q == OP_POP) word_addr = sp_q[BANK_ADDR_WIDTH-1:0] - BANK_ADDR_WIDTH'(1);
  end

  always_comb begin
    bank_en = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_en[i] = exec && (bank_idx == BSEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (BANK_ADDR_WIDTH)
    ) u_bank (
      .clk     (clk),
      .en      (bank_en[g]),
      .we      (bank_we),
      .addr    (word_addr),
      .wr_data (wr_data_q),
      .rd_data (bank_rd[g])
    );
  end

  // rd_data is the read register of the last bank that completed a read;
  // tracking that bank index keeps it stable across later stores and errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q       <= '0;
      rd_bank_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (exec) begin
      if (op_q == OP_PUSH)     sp_q <= sp_q + (BANK_ADDR_WIDTH+1)'(1);
      else if (op_q == OP_POP) sp_q <= sp_q - (BANK_ADDR_WIDTH+1)'(1);
      if (!bank_we) begin
        rd_bank_q  <= bank_idx;
        rd_valid_q <= 1'b1;
      end
    end
  end

  assign ready     = (state_q != ST_ACCESS);
  assign done      = (state_q == ST_RESP);
  assign err       = done && err_q;
  assign rd_data   = rd_valid_q ? bank_rd[rd_bank_q] : '0;
  assign sp        = sp_q;
  assign stk_full  = (sp_q == SP_FULL);
  assign stk_empty = (sp_q == '0);

endmodule

// File: tb/tb_banked_mem_unit.sv
// Directed bench for banked_mem_unit at default parameters (64b, 8 x 4K).
module tb_banked_mem_unit;

  localparam logic [1:0] LD = 2'b00, ST = 2'b01, PU = 2'b10, PO = 2'b11;
  localparam int unsigned DEPTH = 4096;

  logic        clk, rst, req;
  logic [1:0]  op;
  logic [14:0] addr;
  logic [63:0] wr_data;
  logic [7:0]  wp_mask;
  logic        ready, done, err, stk_full, stk_empty;
  logic [63:0] rd_data;
  logic [12:0] sp;

  int checks = 0;
  int errors = 0;

  banked_mem_unit #(
    .DATA_WIDTH      (64),
    .BANK_ADDR_WIDTH (12),
    .NUM_BANKS       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wr_data   (wr_data),
    .wp_mask   (wp_mask),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .sp        (sp),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [14:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        exp_err;
    logic        chk_rd;
    logic [63:0] exp_rd;
    int unsigned exp_sp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with ready=1; returns at the negedge inside RESP.
  task automatic run_op(input logic [1:0] o, input logic [14:0] a, input logic [63:0] d,
                        input logic [7:0] m, input logic exp_err, input logic chk_rd,
                        input logic [63:0] exp_rd, input int unsigned exp_sp,
                        input logic keep, input string name);
    op = o; addr = a; wr_data = d; wp_mask = m; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) req = 1'b0;
    chk({name, " access_ready"}, 64'(ready), 64'd0);
    chk({name, " access_done"}, 64'(done), 64'd0);
    @(posedge clk);
    #1;
    chk({name, " done"}, 64'(done), 64'd1);
    chk({name, " err"}, 64'(err), 64'(exp_err));
    if (chk_rd) chk({name, " rd_data"}, rd_data, exp_rd);
    chk({name, " sp"}, 64'(sp), 64'(exp_sp));
    chk({name, " empty"}, 64'(stk_empty), 64'(exp_sp == 0));
    chk({name, " full"}, 64'(stk_full), 64'(exp_sp == DEPTH));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; op = LD; addr = '0; wr_data = '0; wp_mask = '0;

    //             op  addr      wdata              mask   err chk exp_rd             sp
    vecs[0]  = '{ST, 15'h0004, 64'h1234,          8'h00, 0, 0, 64'h0,            0};
    vecs[1]  = '{ST, 15'h1004, 64'hDEAD_BEEF,     8'h00, 0, 0, 64'h0,            0};
    vecs[2]  = '{LD, 15'h1004, 64'h0,             8'h00, 0, 1, 64'hDEAD_BEEF,    0};
    vecs[3]  = '{LD, 15'h0004, 64'h0,             8'h00, 0, 1, 64'h1234,         0};
    vecs[4]  = '{ST, 15'h1008, 64'h99,            8'h00, 0, 1, 64'h1234,         0};
    vecs[5]  = '{ST, 15'h1008, 64'h5,             8'h02, 1, 1, 64'h1234,         0};
    vecs[6]  = '{LD, 15'h1008, 64'h0,             8'h00, 0, 1, 64'h99,           0};
    vecs[7]  = '{ST, 15'h1008, 64'h6,             8'hFD, 0, 0, 64'h0,            0};
    vecs[8]  = '{LD, 15'h1008, 64'h0,             8'h00, 0, 1, 64'h6,            0};
    vecs[9]  = '{PO, 15'h0000, 64'h0,             8'h00, 1, 1, 64'h6,            0};
    vecs[10] = '{PU, 15'h0000, 64'hAB,            8'h80, 0, 1, 64'h6,            1};
    vecs[11] = '{LD, 15'h7000, 64'h0,             8'h00, 0, 1, 64'hAB,           1};
    vecs[12] = '{ST, 15'h2000, 64'h1,             8'h00, 0, 0, 64'h0,            1};
    vecs[13] = '{ST, 15'h7000, 64'h55,            8'h80, 1, 1, 64'hAB,           1};
    vecs[14] = '{PO, 15'h0000, 64'h0,             8'h00, 0, 1, 64'hAB,           0};

    repeat (2) @(negedge clk);
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst rd_data", rd_data, 64'd0);
    chk("rst sp", 64'(sp), 64'd0);
    chk("rst empty", 64'(stk_empty), 64'd1);
    chk("rst full", 64'(stk_full), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].exp_err,
             vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_sp, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-to-back with req held high through RESP
    run_op(PU, '0, 64'h11, '0, 0, 0, '0, 1, 1'b1, "push11");
    run_op(PU, '0, 64'h22, '0, 0, 0, '0, 2, 1'b1, "push22");
    run_op(PU, '0, 64'h33, '0, 0, 0, '0, 3, 1'b0, "push33");
    run_op(PO, '0, '0, '0, 0, 1, 64'h33, 2, 1'b1, "pop33");
    run_op(PO, '0, '0, '0, 0, 1, 64'h22, 1, 1'b1, "pop22");
    run_op(PO, '0, '0, '0, 0, 1, 64'h11, 0, 1'b0, "pop11");

    // Fill the stack completely, then overflow and pop the last entry
    for (int i = 0; i < int'(DEPTH); i++) begin
      run_op(PU, '0, 64'h1000 + 64'(i), '0, 0, 0, '0, i + 1, 1'b0, "fill");
    end
    run_op(PU, '0, 64'hFFFF, '0, 1, 1, 64'h11, DEPTH, 1'b0, "push_full");
    run_op(PO, '0, '0, '0, 0, 1, 64'h1FFF, DEPTH - 1, 1'b0, "pop_top");

    // Reset during ACCESS aborts a STORE to 0x2000
    op = ST; addr = 15'h2000; wr_data = 64'h7; wp_mask = '0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort ready", 64'(ready), 64'd1);
    chk("abort done", 64'(done), 64'd0);
    chk("abort err", 64'(err), 64'd0);
    chk("abort rd_data", rd_data, 64'd0);
    chk("abort sp", 64'(sp), 64'd0);
    chk("abort empty", 64'(stk_empty), 64'd1);
    chk("abort full", 64'(stk_full), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort no_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(LD, 15'h2000, '0, '0, 0, 1, 64'h1, 0, 1'b0, "load_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
